spi_mem_ctrl: RTL and testbench
===============================

# spi_mem_ctrl

Host-side serial master for the SPI memory slave. It accepts single byte read/write requests on a valid/ready host port, serialises them onto the slave's `cs`/`miso` pins, and deserialises read data from the slave's `mosi` pin. It returns one response per request and guards against a dead slave with a timeout.

## Interface
- `TIMEOUT`, default 64: maximum number of cycles spent waiting for the slave's `ready` or `op_done` before an error response is returned.
- `RECOVER`, default 24: number of cycles `req_ready` is held low after reset release.
- `clk` in 1: single clock; all logic samples on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: controller can accept a request.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_addr` in 8: memory address.
- `req_wdata` in 8: write data. Ignored on reads.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 8: read data. 0 on writes and on error.
- `rsp_err` out 1: timeout flag, qualified by `rsp_valid`.
- `busy` out 1: high from accept through the response cycle.
- `cs` out 1: slave select, active-low.
- `miso` out 1: serial data to the slave.
- `mosi` in 1: serial data from the slave.
- `ready` in 1: slave read data valid.
- `op_done` in 1: slave completion strobe.

## Operation
- **Reset values:** `cs`=1, `miso`=0, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0. State is RECOVER.
- **All outputs are registered.** Bits are sent and received LSB first.
- **RECOVER:** counts `RECOVER` cycles with `cs`=1, then moves to IDLE. This lets a slave that was interrupted mid-frame drain back to idle.
- **IDLE:** `req_ready`=1. When `req_valid`&`req_ready`, the controller latches `req_wr`, `req_addr` and `req_wdata` into a 16-bit shift register ({wdata, addr}) and moves to CMD.
- **CMD (2 cycles):** `cs`=0 and `miso`=`req_wr` in both cycles.
- **ADDR (8 cycles):** `cs`=0, `miso`=addr[0..7], one bit per cycle.
- **Write path:**
  - WDATA (8 cycles): `cs`=0, `miso`=wdata[0..7].
  - DONE_WAIT: `cs`=1, `miso`=0. Waits for `op_done`=1.
- **Read path:**
  - RD_WAIT: `cs`=1, `miso`=0. Waits for `ready`=1.
  - RDATA: on the first edge that samples `ready`=1, and on the 7 following edges, shift `mosi` into rdata[0..7].
  - Then DONE_WAIT.
- **RESP (1 cycle):** `rsp_valid`=1 with `rsp_rdata` and `rsp_err`. Returns to IDLE.
- **Timeout:** the wait counter clears on entry to RD_WAIT and to DONE_WAIT. If it reaches `TIMEOUT` in either state, go to RESP with `rsp_err`=1 and `rsp_rdata`=0. `cs` stays 1.
- **Reset mid-frame:** `cs` goes to 1 immediately (asynchronous). The partial request is discarded with no response. The controller re-enters RECOVER.
- **`cs` must be 1** from the cycle after the last address bit (read) or last data bit (write) until the next CMD. The slave re-arms on `cs` low in its idle state.
- **`req_valid` held while busy:** no effect; `req_ready`=0.
- **`ready`/`op_done` outside their wait states:** ignored.

## Timing
- Cycle numbering: cycle 0 is the first cycle after the accepting edge.
- Write:
  - CMD cycles 0–1, addr cycles 2–9, wdata cycles 10–17.
  - `cs`=1 from cycle 18.
  - Slave `op_done` is high in cycle 19 and sampled at the end of cycle 19.
  - `rsp_valid` in cycle 20. Next accept is possible at the end of cycle 21.
- Read:
  - CMD cycles 0–1, addr cycles 2–9, `cs`=1 from cycle 10.
  - Slave `ready` rises in cycle 12; rdata bits are sampled at the ends of cycles 12–19.
  - `op_done` is sampled at the end of cycle 20.
  - `rsp_valid` in cycle 21.
- Timeout response: `rsp_valid` appears `TIMEOUT`+1 cycles after entering the wait state.
- Throughput: one request in flight; no pipelining.

## Structure
- Package `spi_mem_pkg` holds:
  - the state enum: RECOVER, IDLE, CMD, ADDR, WDATA, RD_WAIT, RDATA, DONE_WAIT, RESP;
  - `OP_WRITE`=1 and `OP_READ`=0;
  - `CMD_LEN`=2, `ADDR_LEN`=8, `DATA_LEN`=8.
- One sub-module, `spi_ctrl_shreg`:
  - 16-bit LSB-first shift register with parallel load, serial-out and serial-in;
  - shared between the transmit path (addr/wdata) and the receive path (rdata).
- The bit counter, wait counter and FSM live in the top module.

## Test plan
- Write addr=0x05, wdata=0xA5:
  - `cs` low in cycles 0–17;
  - `miso` sequence 1,1, then 1,0,1,0,0,0,0,0, then 1,0,1,0,0,1,0,1;
  - `rsp_valid` in cycle 20 with `rsp_err`=0.
- Read addr=0x05 after that write: `rsp_rdata`=0xA5 in cycle 21, `rsp_err`=0.
- Slave model never asserts `ready` (read addr=0x03): `rsp_err`=1, `rsp_rdata`=0, `cs`=1 throughout the wait.
- Back-to-back: write 0x1F←0x3C, then read 0x1F with `req_valid` held high. The second request is accepted only after RESP, and the read returns 0x3C.
- Assert `rst` low at cycle 9 of a write:
  - `cs`=1 in the same cycle; no `rsp_valid`;
  - `req_ready` stays 0 for 24 cycles after release;
  - a following read of that address returns the prior contents or a defined value, with no hang.
- With `req_valid` high during RECOVER: no accept until `req_ready` rises.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared FSM states, opcode values and frame field lengths for the SPI memory host.
package spi_mem_pkg;
    typedef enum logic [3:0] {
        ST_RECOVER, ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA,
        ST_RD_WAIT, ST_RDATA, ST_DONE_WAIT, ST_RESP
    } state_t;
    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;
    localparam int CMD_LEN  = 2;
    localparam int ADDR_LEN = 8;
    localparam int DATA_LEN = 8;
endpackage

// File: rtl/spi_ctrl_shreg.sv
// spi_ctrl_shreg: 16-bit LSB-first shift register; loads {wdata, addr}, shifts out bit 0, shifts in at bit 15.
module spi_ctrl_shreg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift,
    input  logic        sin,
    input  logic [15:0] din,
    output logic        sout,
    output logic [7:0]  rdata
);
    logic [15:0] q;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            q <= '0;
        else if (load)
            q <= din;
        else if (shift)
            q <= {sin, q[15:1]};
    assign sout  = q[0];
    assign rdata = q[15:8];
endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: SPI memory host controller; one byte read/write per request, slave timeout and post-reset recovery.
module spi_mem_ctrl
    import spi_mem_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int RECOVER = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       cs,
    output logic       miso,
    input  logic       mosi,
    input  logic       ready,
    input  logic       op_done
);
    localparam int WW = $clog2((TIMEOUT > RECOVER ? TIMEOUT : RECOVER) + 1);
    state_t        state;
    logic [2:0]    bcnt;
    logic [WW-1:0] wcnt;
    logic          wr, last, wait_to, load, shift, sout;
    logic [7:0]    rx_data;
    spi_ctrl_shreg u_shreg (
        .clk(clk), .rst(rst), .load(load), .shift(shift), .sin(mosi),
        .din({req_wdata, req_addr}), .sout(sout), .rdata(rx_data)
    );
    always_comb begin
        last    = (state == ST_CMD)   ? bcnt == 3'(CMD_LEN - 1) :
                  (state == ST_ADDR)  ? bcnt == 3'(ADDR_LEN - 1) :
                  (state == ST_RDATA) ? bcnt == 3'(DATA_LEN - 2) : bcnt == 3'(DATA_LEN - 1);
        wait_to = wcnt == WW'(TIMEOUT);
        load    = state == ST_IDLE && req_valid && req_ready;
        // the first received bit is taken on the same edge that sees ready
        shift   = (state == ST_CMD && last) || state == ST_ADDR || state == ST_WDATA ||
                  (state == ST_RD_WAIT && ready) || state == ST_RDATA;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RECOVER;
            bcnt      <= '0;
            wcnt      <= '0;
            wr        <= 1'b0;
            cs        <= 1'b1;
            miso      <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_RECOVER:
                    if (wcnt == WW'(RECOVER - 1)) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else
                        wcnt <= wcnt + 1'b1;
                ST_IDLE:
                    if (req_valid) begin
                        state     <= ST_CMD;
                        wr        <= req_wr;
                        bcnt      <= '0;
                        cs        <= 1'b0;
                        miso      <= req_wr;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                ST_CMD: begin
                    bcnt <= last ? 3'd0 : bcnt + 3'd1;
                    if (last) begin
                        state <= ST_ADDR;
                        miso  <= sout;
                    end
                end
                ST_ADDR: begin
                    bcnt <= last ? 3'd0 : bcnt + 3'd1;
                    if (last && wr != OP_WRITE) begin
                        state <= ST_RD_WAIT;
                        cs    <= 1'b1;
                        miso  <= 1'b0;
                        wcnt  <= '0;
                    end else begin
                        miso <= sout;
                        if (last)
                            state <= ST_WDATA;
                    end
                end
                ST_WDATA:
                    if (last) begin
                        state <= ST_DONE_WAIT;
                        cs    <= 1'b1;
                        miso  <= 1'b0;
                        wcnt  <= '0;
                    end else begin
                        bcnt <= bcnt + 3'd1;
                        miso <= sout;
                    end
                ST_RD_WAIT:
                    if (ready) begin
                        state <= ST_RDATA;
                        bcnt  <= '0;
                    end else if (wait_to) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else
                        wcnt <= wcnt + 1'b1;
                ST_RDATA:
                    if (last) begin
                        state <= ST_DONE_WAIT;
                        wcnt  <= '0;
                    end else
                        bcnt <= bcnt + 3'd1;
                ST_DONE_WAIT:
                    if (op_done || wait_to) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !op_done;
                        rsp_rdata <= (op_done && wr == OP_READ) ? rx_data : 8'h00;
                    end else
                        wcnt <= wcnt + 1'b1;
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= ST_RECOVER;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: randomized scoreboard bench with a behavioural SPI memory slave and directed timing traces.
module tb_spi_mem_ctrl;
    localparam int TIMEOUT = 64;
    localparam int RECOVER = 24;
    logic clk = 1'b0, rst = 1'b0;
    logic req_valid = 1'b0, req_wr = 1'b0;
    logic [7:0] req_addr = '0, req_wdata = '0;
    logic req_ready, rsp_valid, rsp_err, busy, cs, miso;
    logic [7:0] rsp_rdata;
    logic mosi = 1'b0, ready = 1'b0, op_done = 1'b0;
    int tests = 0, fails = 0;
    bit dead = 1'b0;
    logic [7:0] smem [256];
    logic [7:0] ref_mem [256];
    logic [8:0] sbq [$];
    logic [8:0] mon_exp;
    logic [127:0] t_cs, t_miso, t_rv, t_busy, t_rr;
    logic [7:0] t_rd;
    logic t_err;

    spi_mem_ctrl #(.TIMEOUT(TIMEOUT), .RECOVER(RECOVER)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .cs(cs), .miso(miso), .mosi(mosi), .ready(ready), .op_done(op_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] ones(input int lo, input int hi);
        logic [127:0] r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [127:0] frame_bits(input logic w, input logic [7:0] a, input logic [7:0] d);
        logic [127:0] r = '0;
        r[0] = w;
        r[1] = w;
        for (int i = 0; i < 8; i++) begin
            r[2 + i] = a[i];
            if (w) r[10 + i] = d[i];
        end
        return r;
    endfunction

    // memory slave: collects the frame bit by bit, abandons it if cs rises or reset hits
    task automatic slave_frame();
        logic [17:0] b = '0;
        b[0] = miso;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            if (cs || !rst) return;
            b[i] = miso;
        end
        if (b[0]) begin
            for (int i = 10; i < 18; i++) begin
                @(negedge clk);
                if (cs || !rst) return;
                b[i] = miso;
            end
            repeat (2) @(negedge clk);
            if (!dead) begin
                op_done = 1'b1;
                smem[b[9:2]] = b[17:10];
            end
            @(negedge clk);
            op_done = 1'b0;
        end else if (!dead) begin
            repeat (3) @(negedge clk);
            ready = 1'b1;
            mosi  = smem[b[9:2]][0];
            for (int i = 1; i < 8; i++) begin
                @(negedge clk);
                mosi = smem[b[9:2]][i];
            end
            @(negedge clk);
            ready   = 1'b0;
            mosi    = 1'b0;
            op_done = 1'b1;
            @(negedge clk);
            op_done = 1'b0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst && !cs) slave_frame();
    end

    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got err=%b rdata=%0h expected no response", rsp_err, rsp_rdata);
            end else begin
                mon_exp = sbq.pop_front();
                check("rsp", {rsp_err, rsp_rdata}, mon_exp);
            end
        end
    end

    // called at a negedge; returns at the negedge of cycle 0 of the accepted request
    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input bit push, input bit hold, output int waited);
        req_valid = 1'b1;
        req_wr    = w;
        req_addr  = a;
        req_wdata = d;
        waited    = 0;
        while (!req_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no req_ready after %0d cycles expected accept", waited);
            req_valid = 1'b0;
            return;
        end
        if (push) begin
            if (w) begin
                sbq.push_back(9'h000);
                ref_mem[a] = d;
            end else
                sbq.push_back(dead ? 9'h100 : {1'b0, ref_mem[a]});
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got req_ready=0 after %0d cycles expected 1", n);
        end
    endtask

    task automatic trace(input int n);
        t_cs = '0; t_miso = '0; t_rv = '0; t_busy = '0; t_rr = '0; t_rd = '0; t_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            t_cs[i] = cs; t_miso[i] = miso; t_rv[i] = rsp_valid; t_busy[i] = busy; t_rr[i] = req_ready;
            if (rsp_valid) begin
                t_rd  = rsp_rdata;
                t_err = rsp_err;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt;
        bit rv_seen;
        logic w;
        logic [7:0] a, d;
        for (int i = 0; i < 256; i++) begin
            smem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("reset_state", {cs, miso, req_ready, rsp_valid, rsp_err, busy, rsp_rdata}, {6'b100000, 8'h00});
        rst = 1'b1;
        // request held through RECOVER is accepted only once req_ready rises
        issue(1'b1, 8'h05, 8'hA5, 1'b1, 1'b0, wt);
        check("recover_wait", wt, RECOVER);
        trace(22);
        check("wr_cs", t_cs, ones(18, 21));
        check("wr_miso", t_miso, frame_bits(1'b1, 8'h05, 8'hA5));
        check("wr_rsp_cycle", t_rv, ones(20, 20));
        check("wr_err", t_err, 1'b0);
        check("wr_busy", t_busy, ones(0, 20));
        check("wr_req_ready", t_rr, ones(21, 21));
        issue(1'b0, 8'h05, 8'h00, 1'b1, 1'b0, wt);
        check("rd_accept_cycle21", wt, 0);
        trace(23);
        check("rd_cs", t_cs, ones(10, 22));
        check("rd_miso", t_miso, frame_bits(1'b0, 8'h05, 8'h00));
        check("rd_rsp_cycle", t_rv, ones(21, 21));
        check("rd_data", {t_err, t_rd}, 9'h0A5);
        dead = 1'b1;
        issue(1'b0, 8'h03, 8'h00, 1'b1, 1'b0, wt);
        trace(80);
        check("to_cs", t_cs, ones(10, 79));
        check("to_rsp_cycle", t_rv, ones(TIMEOUT + 11, TIMEOUT + 11));
        check("to_resp", {t_err, t_rd}, 9'h100);
        dead = 1'b0;
        issue(1'b1, 8'h1F, 8'h3C, 1'b1, 1'b1, wt);
        issue(1'b0, 8'h1F, 8'h00, 1'b1, 1'b0, wt);
        check("b2b_accept_wait", wt, 21);
        wait_idle();
        issue(1'b1, 8'h40, 8'h11, 1'b1, 1'b0, wt);
        wait_idle();
        // reset lands in cycle 9 of a write that must leave no trace
        issue(1'b1, 8'h40, 8'h99, 1'b0, 1'b0, wt);
        rv_seen = rsp_valid;
        repeat (9) begin
            @(negedge clk);
            rv_seen |= rsp_valid;
        end
        rst = 1'b0;
        #1;
        check("rst_async_out", {cs, rsp_valid, req_ready, busy}, 4'b1000);
        repeat (3) begin
            @(negedge clk);
            rv_seen |= rsp_valid;
        end
        check("rst_no_rsp", rv_seen, 1'b0);
        rst = 1'b1;
        issue(1'b0, 8'h40, 8'h00, 1'b1, 1'b0, wt);
        check("rst_recover_wait", wt, RECOVER);
        wait_idle();
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w = 1'($urandom_range(0, 1));
            a = 8'h10 + 8'($urandom_range(0, 7));
            d = 8'($urandom);
            if (!w && $urandom_range(0, 7) == 0) begin
                req_valid = 1'b0;
                wait_idle();
                dead = 1'b1;
                issue(1'b0, a, 8'h00, 1'b1, 1'b0, wt);
                wait_idle();
                dead = 1'b0;
            end else
                issue(w, a, d, 1'b1, $urandom_range(0, 3) == 0, wt);
        end
        req_valid = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("sb_drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
